// File: rtl/acq_sched_pkg.sv
// Shared types and widths for the acquisition scheduler.
package acq_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int FRAME_W = 16;
    localparam int WAIT_W  = 32;

endpackage

// File: rtl/acq_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at last+1 and wraps.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // First pass covers indices above last, second pass wraps to the rest.
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (j > int'(last))) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acq_scheduler.sv
// Shares one BRAM capture window between requesters: round-robin grant,
// wait for address wrap, then write enable for whole frames.
module acq_scheduler
    import acq_sched_pkg::*;
#(
    parameter int BRAM_WIDTH = 13,
    parameter int N_REQ      = 2,
    parameter int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [FRAME_W-1:0]    n_frames,
    input  logic                  abort,
    input  logic [BRAM_WIDTH-1:0] address,
    output logic [N_REQ-1:0]      grant,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic                  wen,
    output logic                  frame_start,
    output logic [N_REQ-1:0]      done,
    output logic                  aborted,
    output logic [WAIT_W-1:0]     wait_cycles
);

    // Handshake: a requester raises req and holds it; grant marks ownership
    // from the cycle after arbitration through DONE; done pulses once and the
    // requester must drop req afterwards or it is seen as a new request.
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q;
    logic                 has_owner_q;
    logic [N_REQ-1:0]     grant_q, done_q;
    logic                 aborted_q;
    logic [FRAME_W-1:0]   frames_left_q;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cycles_q;

    logic [N_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]     arb_idx, arb_last;
    logic                 arb_any;
    logic                 addr_zero, addr_last;

    assign addr_zero = (address == '0);
    assign addr_last = &address;

    // Before the first grant the search starts at index 0.
    assign arb_last = has_owner_q ? owner_q : IDX_W'(N_REQ - 1);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req  (req),
        .last (arb_last),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_ARM;
            ST_ARM: begin
                if (abort)          state_d = ST_DONE;
                else if (addr_zero) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort) state_d = ST_DONE;
                else if (addr_last && frames_left_q == FRAME_W'(1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Combinational so the first enable lands exactly on the address-0 cycle.
    assign wen         = (state_q == ST_WRITE) || (state_q == ST_ARM && addr_zero);
    assign frame_start = wen && addr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            has_owner_q   <= 1'b0;
            grant_q       <= '0;
            done_q        <= '0;
            aborted_q     <= 1'b0;
            frames_left_q <= '0;
            wait_cnt_q    <= '0;
            wait_cycles_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= '0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        owner_q       <= arb_idx;
                        has_owner_q   <= 1'b1;
                        grant_q       <= arb_gnt;
                        frames_left_q <= (n_frames == '0) ? FRAME_W'(1) : n_frames;
                        wait_cnt_q    <= '0;
                    end
                end
                ST_ARM: begin
                    if (~&wait_cnt_q) wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (addr_zero)    wait_cycles_q <= wait_cnt_q;
                end
                ST_WRITE: begin
                    if (addr_last && frames_left_q != FRAME_W'(1))
                        frames_left_q <= frames_left_q - 1'b1;
                end
                ST_DONE: grant_q <= '0;
                default: ;
            endcase
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                done_q    <= grant_q;
                aborted_q <= abort;
            end
        end
    end

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign wait_cycles = wait_cycles_q;

endmodule

// File: doc/acq_scheduler.md
# acq_scheduler

Acquisition scheduler that shares one BRAM capture window between `N_REQ` requesters such as a software trigger, an external trigger, or a DMA refill. It arbitrates requests round-robin and waits for the free-running BRAM write address to wrap to zero. It then drives a frame-aligned write enable for a programmable number of full BRAM passes and returns a done/abort status to the owner. It sits between the trigger sources and the BRAM write-enable path of an acquisition chain.

## Interface
- `BRAM_WIDTH`, default 13: BRAM address width; one frame is 2^BRAM_WIDTH cycles.
- `N_REQ`, default 2: number of requesters, minimum 1.
- `IDX_W`, default max(1, clog2(N_REQ)): owner index width (derived).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req`, in, N_REQ: level requests, held by each requester until its `done` bit pulses.
- `n_frames`, in, 16: frames per acquisition, sampled at grant; 0 is treated as 1.
- `abort`, in, 1: terminates the current acquisition.
- `address`, in, BRAM_WIDTH: free-running BRAM address, incrementing by 1 per cycle modulo 2^BRAM_WIDTH (not checked).
- `grant`, out, N_REQ: one-hot owner, high from grant through the DONE cycle.
- `owner`, out, IDX_W: index of the current or last owner.
- `busy`, out, 1: state is not IDLE.
- `wen`, out, 1: BRAM write enable, frame-aligned.
- `frame_start`, out, 1: `wen` AND `address`==0.
- `done`, out, N_REQ: one-cycle pulse to the owner.
- `aborted`, out, 1: valid with `done`; 1 if the acquisition was ended by `abort`.
- `wait_cycles`, out, 32: cycles from grant to first `wen`, saturating, latched at the first frame_start.

## Operation
- FSM states: IDLE, ARM, WRITE, DONE.
- IDLE → ARM when any `req` bit is set:
  - Winner is chosen round-robin, searching from `owner`+1; `owner` holds the last winner.
  - Latch the winner into `owner`/`grant`, latch `frames_left` = max(`n_frames`,1), clear the wait counter.
- ARM:
  - The wait counter increments each cycle, saturating at 2^32-1.
  - When `address`==0: `wen` is high that same cycle, `wait_cycles` is latched, and the FSM goes to WRITE.
- WRITE:
  - `wen` is high every cycle.
  - When `address`==all-ones: if `frames_left`==1 go to DONE, else decrement `frames_left`.
- DONE: one cycle. `done[owner]` is high, `grant` drops on exit, next state IDLE.
- `abort` while in ARM or WRITE:
  - Next state is DONE with `aborted`=1.
  - `wen` goes low from the next cycle on, including mid-frame.
  - `abort` is ignored in IDLE and DONE.
- `wen` and `frame_start` are combinational from the state register and `address`. This is deliberate, so that `wen` coincides exactly with the address-0 cycle. All other outputs are registered.
- A requester must drop `req` after seeing `done`. A `req` still high in the following IDLE cycle is a new request, arbitrated with that requester at lowest priority.
- `n_frames` and `req` changes after grant have no effect on the current acquisition.

## Timing
- Reset values:
  - State IDLE, `owner`=0, so after reset requester 0 wins first under simultaneous requests.
  - `grant`=0, `busy`=0, `done`=0, `aborted`=0, `wen`=0, `frame_start`=0, `wait_cycles`=0, `frames_left`=0.
- Reset mid-acquisition: `wen` is low in the cycle after `rst`. No `done` is issued for the interrupted owner.
- Latency:
  - `req` sampled in IDLE → `grant` high on the next cycle.
  - The first `wen` follows the first `address`==0 at or after the first ARM cycle.
  - If `address` is 0 in the first ARM cycle, `wait_cycles`=0.
- Non-aborted acquisition: exactly `n_frames`·2^BRAM_WIDTH `wen` cycles, contiguous, starting at address 0 and ending at address all-ones.
- `done` pulses the cycle after the last `wen` cycle.
- Back-to-back: DONE → IDLE → ARM. There is a minimum 2-cycle gap between `done` and the next `grant`. The next write then starts at the following address wrap.
- `abort` in the same cycle as the final all-ones address: the abort wins, `aborted`=1, and the total `wen` count is unchanged.

## Structure
- Shared package `acq_sched_pkg`:
  - state enum (IDLE/ARM/WRITE/DONE);
  - frame-counter width constant (16);
  - wait-counter width constant (32).
- Sub-module `rr_arbiter`: N_REQ requests plus last-owner index → one-hot grant and index, purely combinational, with priority starting at last+1. The FSM, counters and output registers live in `acq_scheduler`.

## Test plan
- BRAM_WIDTH=4, `req`=01 raised at address 5, `n_frames`=1 → `grant`=01 next cycle, `wait_cycles`=10, 16 `wen` cycles over addresses 0..15, `done`=01 one cycle later, `aborted`=0.
- `n_frames`=0 and then `n_frames`=3 → 16 and 48 contiguous `wen` cycles respectively, with `frame_start` pulsing 1 and 3 times.
- Both `req` bits held continuously from reset → grants alternate 01, 10, 01, …, each separated by at least 2 cycles after `done`.
- `abort` at the 7th `wen` cycle → `wen` low the next cycle, 7 `wen` cycles in total, then `done` with `aborted`=1.
- `rst` asserted mid-WRITE → `wen`, `grant` and `busy` are 0 the next cycle, no `done` pulse, and requester 0 wins next.
- `address` equal to 0 in the first ARM cycle → `wait_cycles`=0 and `wen` high in that same cycle.
